tanh_lut_loader: RTL and testbench
==================================

Name: tanh_lut_loader

Overview:
- Runtime writer for the 256-entry tanh table consumed by the activation stage. Replaces the static file initialisation.
- Takes a table image over a valid/ready config stream and verifies a trailing 16-bit checksum. On success it swaps the image into a double-buffered RAM.
- Serves registered dual-entry reads (addr, addr+1) to the activation pipeline from the active bank, which is never disturbed by a load.

Parameters:
- DATA_WIDTH, 16, width of each LUT entry (Q1.15) and of the checksum.
- ADDR_WIDTH, 8, LUT address width; DEPTH = 2**ADDR_WIDTH (localparam, 256).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse: begin (or restart) a load session.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  DATA_WIDTH  table entry, or the checksum word.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- rd_en  in  1  read request from activation.
- rd_addr  in  ADDR_WIDTH  base address.
- rd_data0  out  DATA_WIDTH  entry[rd_addr], active bank.
- rd_data1  out  DATA_WIDTH  entry[(rd_addr+1) mod DEPTH], active bank.
- rd_valid  out  1  rd_data0/rd_data1 valid.
- busy  out  1  high in LOAD or CSUM.
- load_done  out  1  one-cycle pulse: checksum matched, banks swapped.
- load_err  out  1  one-cycle pulse: checksum mismatch, banks unchanged.
- table_valid  out  1  sticky high after the first successful load.
- active_bank  out  1  bank currently served to readers.

Behaviour:
- Reset: all outputs 0; state IDLE; word counter and running sum cleared. RAM contents are not reset and are undefined until table_valid=1.
- Handshake: a word is transferred when cfg_valid && cfg_ready. cfg_ready = 1 exactly in LOAD and CSUM. In IDLE, cfg_valid is ignored.
- State IDLE:
  - cfg_start goes to LOAD, clears cnt=0 and sum=0.
- State LOAD:
  - Each transfer writes cfg_data into the inactive bank at address cnt.
  - sum += cfg_data, modulo 2^DATA_WIDTH.
  - cnt increments; the transfer with cnt==DEPTH-1 moves the state to CSUM.
- State CSUM:
  - On transfer, compare cfg_data with sum and return to IDLE.
  - Match: toggle active_bank, set table_valid, pulse load_done the next cycle.
  - Mismatch: pulse load_err the next cycle; nothing else changes.
- cfg_start in LOAD or CSUM aborts and restarts: cnt=0, sum=0, stay/enter LOAD, no pulse. If cfg_start and a transfer occur in the same cycle, cfg_start wins and the word is dropped.
- Reads:
  - rd_valid and rd_data are registered, latency 1 cycle. A new read is accepted every cycle.
  - rd_addr+1 wraps DEPTH-1 to 0.
  - rd_data holds its value when rd_en=0; rd_valid follows rd_en delayed by one cycle.
- Swap timing: a read sampled on the same edge that accepts a matching checksum returns the old bank. The new bank is served from the following edge.
- Reads and writes never touch the same bank, so there are no collision rules. Reads proceed during loads with undisturbed data.
- Reset mid-load abandons the session: active_bank returns to 0 and table_valid returns to 0.

Decomposition:
- Shared package holds:
  - LUT depth and width constants.
  - Q1.15 format constants.
  - Loader state encoding (IDLE, LOAD, CSUM).
  - Checksum width.
- One sub-module, lut_bank_ram: a 256x16 simple dual-port RAM with synchronous write and synchronous two-address read. It is instantiated twice. The top block holds the FSM, counter, checksum and read mux.

Test Plan:
- Ramp load: cfg_start, entries i*16 for i=0..255, then checksum 0xF800 -> load_done pulse once, active_bank=1, table_valid=1. rd_addr=255 -> next cycle rd_data0=0x0FF0, rd_data1=0x0000.
- Bad checksum: after the ramp table, load all entries 0x1000 with checksum 0x0001 (correct is 0x0000) -> load_err pulse, active_bank stays 1, reads still return the ramp values.
- Backpressure: random cfg_valid gaps during load and cfg_valid=1 in IDLE -> cfg_ready=0 in IDLE, exactly 257 transfers per session, result identical to the gap-free load.
- Restart: cfg_start after 100 words, then a full ramp load -> no pulse at the restart, load_done at the end, contents equal the ramp.
- Concurrent read at swap: rd_en each cycle with rd_addr=1 while the matching checksum is accepted -> the read on that edge returns the old bank value, and the next returns 0x0010.
- Reset mid-load: assert rst at word 50 -> all outputs 0, state IDLE, cfg_ready=0; a subsequent full load succeeds with active_bank=1.

Source files
------------

// File: rtl/tanh_lut_loader_pkg.sv
// Shared constants and loader state encoding for the runtime tanh LUT loader.
package tanh_lut_loader_pkg;

  localparam int LUT_DATA_WIDTH = 16;
  localparam int LUT_ADDR_WIDTH = 8;
  localparam int LUT_DEPTH      = 2 ** LUT_ADDR_WIDTH;

  // Q1.15 entries: one sign bit, fifteen fraction bits
  localparam int                        Q15_FRAC_BITS = 15;
  localparam logic [LUT_DATA_WIDTH-1:0] Q15_POS_MAX   = 16'h7FFF;
  localparam logic [LUT_DATA_WIDTH-1:0] Q15_NEG_ONE   = 16'h8000;

  localparam int CSUM_WIDTH = LUT_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CSUM = 2'd2
  } load_state_e;

endpackage

// File: rtl/tanh_lut_loader_bank_ram.sv
// One LUT bank: synchronous write port plus a registered two-address read port.
module lut_bank_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr0_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the read registers are reset; the array itself stays undefined.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (re_i) begin
      rdata0_q <= mem_q[raddr0_i];
      rdata1_q <= mem_q[raddr1_i];
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/tanh_lut_loader.sv
// Runtime tanh LUT writer: checksummed table load into the shadow bank, swap on
// success, and registered dual-entry reads from the active bank.
//   state   | meaning
//   ST_IDLE | no session, cfg stream not accepted
//   ST_LOAD | accepting DEPTH table words into the inactive bank
//   ST_CSUM | waiting for the trailing checksum word
module tanh_lut_loader
  import tanh_lut_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LUT_DATA_WIDTH,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_valid_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  output logic                  cfg_ready_o,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data0_o,
  output logic [DATA_WIDTH-1:0] rd_data1_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic                  table_valid_o,
  output logic                  active_bank_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  load_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] sum_d;
  logic                  active_bank_q;
  logic                  table_valid_q;
  logic                  load_done_q;
  logic                  load_err_q;
  logic                  rd_valid_q;
  logic                  rd_sel_q;

  logic                  in_session;
  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr_next;
  logic [DATA_WIDTH-1:0] b0_rdata0;
  logic [DATA_WIDTH-1:0] b0_rdata1;
  logic [DATA_WIDTH-1:0] b1_rdata0;
  logic [DATA_WIDTH-1:0] b1_rdata1;

  assign in_session   = (state_q == ST_LOAD) || (state_q == ST_CSUM);
  // cfg_start wins over a same-cycle transfer, so the word is simply dropped
  assign accept       = cfg_valid_i && in_session && !cfg_start_i;
  assign wr_en        = accept && (state_q == ST_LOAD);
  assign cnt_d        = cnt_q + ADDR_WIDTH'(1);
  assign sum_d        = sum_q + cfg_data_i;
  assign rd_addr_next = rd_addr_i + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sum_q         <= '0;
      active_bank_q <= 1'b0;
      table_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      if (cfg_start_i) begin
        state_q <= ST_LOAD;
        cnt_q   <= '0;
        sum_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_LOAD: begin
            if (accept) begin
              sum_q <= sum_d;
              cnt_q <= cnt_d;
              if (cnt_q == LAST_ADDR) begin
                state_q <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (accept) begin
              state_q <= ST_IDLE;
              if (cfg_data_i == sum_q) begin
                active_bank_q <= ~active_bank_q;
                table_valid_q <= 1'b1;
                load_done_q   <= 1'b1;
              end else begin
                load_err_q <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Bank select is captured with the read, so a read on the swap edge sees the old bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_sel_q <= active_bank_q;
      end
    end
  end

  lut_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wr_en && active_bank_q),
    .waddr_i  (cnt_q),
    .wdata_i  (cfg_data_i),
    .re_i     (rd_en_i),
    .raddr0_i (rd_addr_i),
    .raddr1_i (rd_addr_next),
    .rdata0_o (b0_rdata0),
    .rdata1_o (b0_rdata1)
  );

  lut_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wr_en && !active_bank_q),
    .waddr_i  (cnt_q),
    .wdata_i  (cfg_data_i),
    .re_i     (rd_en_i),
    .raddr0_i (rd_addr_i),
    .raddr1_i (rd_addr_next),
    .rdata0_o (b1_rdata0),
    .rdata1_o (b1_rdata1)
  );

  assign rd_data0_o    = rd_sel_q ? b1_rdata0 : b0_rdata0;
  assign rd_data1_o    = rd_sel_q ? b1_rdata1 : b0_rdata1;
  assign rd_valid_o    = rd_valid_q;
  assign cfg_ready_o   = in_session;
  assign busy_o        = in_session;
  assign load_done_o   = load_done_q;
  assign load_err_o    = load_err_q;
  assign table_valid_o = table_valid_q;
  assign active_bank_o = active_bank_q;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Scoreboard bench for tanh_lut_loader: session-level table model, queued
// read/pulse expectations checked by an independent monitor.
module tb_tanh_lut_loader;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic [DW-1:0] cfg_data_i = '0;
  logic          cfg_ready_o;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [DW-1:0] rd_data0_o;
  logic [DW-1:0] rd_data1_o;
  logic          rd_valid_o;
  logic          busy_o;
  logic          load_done_o;
  logic          load_err_o;
  logic          table_valid_o;
  logic          active_bank_o;

  always #5 clk_i = ~clk_i;

  tanh_lut_loader dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_start_i   (cfg_start_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_data_i    (cfg_data_i),
    .cfg_ready_o   (cfg_ready_o),
    .rd_en_i       (rd_en_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data0_o    (rd_data0_o),
    .rd_data1_o    (rd_data1_o),
    .rd_valid_o    (rd_valid_o),
    .busy_o        (busy_o),
    .load_done_o   (load_done_o),
    .load_err_o    (load_err_o),
    .table_valid_o (table_valid_o),
    .active_bank_o (active_bank_o)
  );

  typedef struct {
    bit          chk;
    logic [15:0] d0;
    logic [15:0] d1;
  } rd_exp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  rd_exp_t     rdq[$];
  bit          evq[$];
  rd_exp_t     last_rd;
  int          xfer_cnt = 0;

  // Reference model: two table images, which one is live, and the words of
  // the session in progress.
  logic [15:0] m_bank [2][DEPTH];
  int          m_active = 0;
  bit          m_tv = 0;
  bit          m_in_sess = 0;
  logic [15:0] sess[$];

  logic [15:0] ramp_w [DEPTH];
  logic [15:0] flat_w [DEPTH];
  logic [15:0] rnd_w  [DEPTH];
  logic [15:0] rnd2_w [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] csum_of(input logic [15:0] w [DEPTH]);
    logic [15:0] s = 16'h0;
    for (int i = 0; i < DEPTH; i++) s = s + w[i];
    return s;
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a result.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rd_valid_o) begin
        if (rdq.size() == 0) begin
          check("rd_valid_unexpected", {31'b0, rd_valid_o}, 32'h0);
        end else begin
          last_rd = rdq.pop_front();
          if (last_rd.chk) begin
            check("rd_data0", {16'h0, rd_data0_o}, {16'h0, last_rd.d0});
            check("rd_data1", {16'h0, rd_data1_o}, {16'h0, last_rd.d1});
          end
        end
      end else if (last_rd.chk) begin
        check("rd_hold0", {16'h0, rd_data0_o}, {16'h0, last_rd.d0});
        check("rd_hold1", {16'h0, rd_data1_o}, {16'h0, last_rd.d1});
      end
      if (load_done_o || load_err_o) begin
        if (evq.size() == 0) begin
          check("pulse_unexpected", {30'b0, load_done_o, load_err_o}, 32'h0);
        end else begin
          bit ev_done;
          ev_done = evq.pop_front();
          check("pulse_kind", {30'b0, load_done_o, load_err_o}, ev_done ? 32'h2 : 32'h1);
          check("xfers_per_session", xfer_cnt, 257);
        end
        xfer_cnt = 0;
      end
      if (cfg_start_i) xfer_cnt = 0;
      else if (cfg_valid_i && cfg_ready_o) xfer_cnt++;
    end
  end

  task automatic drive_cycle(input bit start, input bit valid, input logic [15:0] data,
                             input bit ren, input logic [7:0] raddr, output bit xfer);
    rd_exp_t     e;
    logic [7:0]  a1;
    logic [15:0] s;
    cfg_start_i = start;
    cfg_valid_i = valid;
    cfg_data_i  = data;
    rd_en_i     = ren;
    rd_addr_i   = raddr;
    if (ren) begin
      a1    = raddr + 8'd1;
      e.chk = m_tv;
      e.d0  = m_bank[m_active][raddr];
      e.d1  = m_bank[m_active][a1];
      rdq.push_back(e);
    end
    xfer = valid && m_in_sess && !start;
    if (start) begin
      m_in_sess = 1;
      sess.delete();
    end else if (xfer) begin
      if (sess.size() < DEPTH) begin
        sess.push_back(data);
      end else begin
        s = 16'h0;
        foreach (sess[i]) s = s + sess[i];
        if (s == data) begin
          for (int i = 0; i < DEPTH; i++) m_bank[1-m_active][i] = sess[i];
          m_active = 1 - m_active;
          m_tv     = 1;
          evq.push_back(1'b1);
        end else begin
          evq.push_back(1'b0);
        end
        m_in_sess = 0;
      end
    end
    @(posedge clk_i);
    #1;
    check("cfg_ready", {31'b0, cfg_ready_o}, {31'b0, m_in_sess});
    check("busy", {31'b0, busy_o}, {31'b0, m_in_sess});
    check("active_bank", {31'b0, active_bank_o}, m_active);
    check("table_valid", {31'b0, table_valid_o}, {31'b0, m_tv});
  endtask

  // Sends start then DEPTH words and a checksum; stops early after stop_at
  // accepted words. rd_fix >= 0 reads that address every cycle.
  task automatic load_table(input logic [15:0] words [DEPTH], input logic [15:0] csum,
                            input int gap_pct, input int stop_at, input bit do_reads,
                            input int rd_fix);
    int          idx = 0;
    int          guard = 0;
    bit          x;
    bit          v;
    bit          ren;
    logic [7:0]  ra;
    logic [15:0] d;
    drive_cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 8'h0, x);
    while (idx < DEPTH + 1 && idx != stop_at) begin
      v   = ($urandom_range(0, 99) >= gap_pct);
      d   = (idx < DEPTH) ? words[idx] : csum;
      ren = (rd_fix >= 0) ? 1'b1 : (do_reads && ($urandom_range(0, 3) != 0));
      ra  = (rd_fix >= 0) ? 8'(rd_fix) : 8'($urandom);
      drive_cycle(1'b0, v, v ? d : 16'($urandom), ren, ra, x);
      if (x) idx++;
      guard++;
      if (guard > 5000) begin
        check("load_progress", idx, 32'(DEPTH + 1));
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_i       = 1'b1;
    cfg_start_i = 1'b0;
    cfg_valid_i = 1'b0;
    rd_en_i     = 1'b0;
    m_active    = 0;
    m_tv        = 0;
    m_in_sess   = 0;
    sess.delete();
    rdq.delete();
    evq.delete();
    xfer_cnt    = 0;
    last_rd     = '{chk: 1'b1, d0: 16'h0, d1: 16'h0};
    #2;
    check("rst_cfg_ready", {31'b0, cfg_ready_o}, 32'h0);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    check("rst_rd_data0", {16'h0, rd_data0_o}, 32'h0);
    check("rst_rd_data1", {16'h0, rd_data1_o}, 32'h0);
    check("rst_load_done", {31'b0, load_done_o}, 32'h0);
    check("rst_load_err", {31'b0, load_err_o}, 32'h0);
    check("rst_table_valid", {31'b0, table_valid_o}, 32'h0);
    check("rst_active_bank", {31'b0, active_bank_o}, 32'h0);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    for (int i = 0; i < DEPTH; i++) begin
      ramp_w[i] = 16'(i * 16);
      flat_w[i] = 16'h1000;
      rnd_w[i]  = 16'($urandom);
      rnd2_w[i] = 16'($urandom);
    end
    #1;
    apply_reset();

    // cfg_valid in IDLE must be ignored
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 16'($urandom), 1'b0, 8'h0, x);

    // ramp table, gap-free
    load_table(ramp_w, 16'hF800, 0, -1, 1'b0, -1);
    drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'hFF, x);
    drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, x);
    drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, x);

    // wrong checksum (correct one is 0x0000)
    load_table(flat_w, 16'h0001, 0, -1, 1'b1, -1);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'($urandom), x);

    // backpressure with random gaps
    load_table(rnd_w, csum_of(rnd_w), 40, -1, 1'b1, -1);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'($urandom), x);

    // restart after 100 words, then a full ramp with reads of address 1 across the swap
    load_table(rnd2_w, csum_of(rnd2_w), 20, 100, 1'b1, -1);
    load_table(ramp_w, 16'hF800, 0, -1, 1'b0, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'h01, x);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'($urandom), x);

    // reset in the middle of a load, then a clean load
    load_table(rnd_w, csum_of(rnd_w), 10, 50, 1'b1, -1);
    apply_reset();
    load_table(rnd2_w, csum_of(rnd2_w), 0, -1, 1'b0, -1);
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'($urandom), x);

    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, x);
    check("reads_outstanding", rdq.size(), 32'h0);
    check("pulses_outstanding", evq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
